// File: rtl/aibnd_dcc_pkg.sv
`default_nettype none
// ============================================================================
// Module : aibnd_dcc_pkg
// Brief  : Shared types and helpers for the DCC clock-mux select sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package aibnd_dcc_pkg;

    localparam int DCC_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_GATE   = 3'd2,
        ST_SWITCH = 3'd3,
        ST_UNGATE = 3'd4,
        ST_DONE   = 3'd5
    } dcc_state_t;

    // A zero dwell request still spends one cycle in the phase.
    function automatic logic [31:0] dwell_clamp(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aibnd_dcc_dly_cnt.sv
`default_nettype none
// ============================================================================
// Module : aibnd_dcc_dly_cnt
// Brief  : Loadable dwell down-counter; clamps 0 to 1 on load, holds at 1.
// Rev    : 1.0 - initial release
// ============================================================================
module aibnd_dcc_dly_cnt
    import aibnd_dcc_pkg::*;
#(
    parameter int CNT_W   = DCC_CNT_W,
    parameter int RST_VAL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             term
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CNT_W'(dwell_clamp(32'(RST_VAL)));
        end else if (load) begin
            r_cnt <= CNT_W'(dwell_clamp(32'(load_val)));
        end else if (!term) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    // Terminal on the last cycle of the dwell; the phase exits on this edge.
    assign term = (r_cnt <= c_one);

endmodule
`default_nettype wire

// File: rtl/aibnd_dcc_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module : aibnd_dcc_mux_ctrl
// Brief  : Glitch-free DCC clock-mux select sequencer with 4-phase handshake.
// Rev    : 1.0 - initial release
// ============================================================================
module aibnd_dcc_mux_ctrl
    import aibnd_dcc_pkg::*;
#(
    parameter int   CNT_W    = DCC_CNT_W,
    parameter int   INIT_CYC = 8,
    parameter logic RST_SEL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_req,
    input  logic             sw_sel,
    input  logic [CNT_W-1:0] gate_dly,
    input  logic [CNT_W-1:0] settle_dly,
    output logic             sw_ack,
    output logic             mux_s,
    output logic             gate_en,
    output logic             busy
);

    dcc_state_t       r_state;
    dcc_state_t       w_state_nxt;
    logic             r_sel;
    logic [CNT_W-1:0] r_gate_dly;
    logic [CNT_W-1:0] r_settle_dly;
    logic             r_req_q;
    logic             w_accept;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_term;
    logic             w_mux_nxt;
    logic             w_gate_nxt;
    logic             w_ack_nxt;
    logic             w_busy_nxt;

    assign w_accept = (r_state == ST_IDLE) && sw_req;

    aibnd_dcc_dly_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (INIT_CYC)
    ) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .term     (w_term)
    );

    // Outputs are decoded from the current state and registered, so each
    // output lags its state by one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            mux_s        <= RST_SEL;
            gate_en      <= 1'b0;
            sw_ack       <= 1'b0;
            busy         <= 1'b1;
            r_sel        <= RST_SEL;
            r_gate_dly   <= '0;
            r_settle_dly <= '0;
            r_req_q      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            mux_s   <= w_mux_nxt;
            gate_en <= w_gate_nxt;
            sw_ack  <= w_ack_nxt;
            busy    <= w_busy_nxt;
            r_req_q <= sw_req;
            if (w_accept) begin
                r_sel        <= sw_sel;
                r_gate_dly   <= gate_dly;
                r_settle_dly <= settle_dly;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:   if (w_term) w_state_nxt = ST_IDLE;
            ST_IDLE:   if (sw_req) w_state_nxt = (sw_sel == mux_s) ? ST_DONE : ST_GATE;
            ST_GATE:   if (w_term) w_state_nxt = ST_SWITCH;
            ST_SWITCH: if (w_term) w_state_nxt = ST_UNGATE;
            ST_UNGATE: if (w_term) w_state_nxt = ST_DONE;
            ST_DONE:   if (!sw_req) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_INIT;
        endcase

        // GATE entry happens on the accept edge, so its dwell comes from the port.
        w_load     = (w_state_nxt != r_state) &&
                     (w_state_nxt inside {ST_GATE, ST_SWITCH, ST_UNGATE});
        w_load_val = '0;
        case (w_state_nxt)
            ST_GATE:   w_load_val = gate_dly;
            ST_SWITCH: w_load_val = r_settle_dly;
            ST_UNGATE: w_load_val = r_gate_dly;
            default:   w_load_val = '0;
        endcase
    end

    always_comb begin
        w_busy_nxt = (r_state != ST_IDLE);
        w_mux_nxt  = (r_state == ST_SWITCH) ? r_sel : mux_s;
        // r_req_q masks the ack when the request was dropped before DONE.
        w_ack_nxt  = (r_state == ST_DONE) && r_req_q;
        case (r_state)
            ST_IDLE, ST_UNGATE, ST_DONE: w_gate_nxt = 1'b1;
            default:                     w_gate_nxt = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_aibnd_dcc_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_aibnd_dcc_mux_ctrl
// Brief  : Scoreboard bench: per-edge expected outputs queued, checked on negedge.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_aibnd_dcc_mux_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             sw_req;
    logic             sw_sel;
    logic [CNT_W-1:0] gate_dly;
    logic [CNT_W-1:0] settle_dly;
    logic             sw_ack;
    logic             mux_s;
    logic             gate_en;
    logic             busy;

    typedef struct {
        int         cyc;
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   edge_n  = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    aibnd_dcc_mux_ctrl #(
        .CNT_W    (CNT_W),
        .INIT_CYC (8),
        .RST_SEL  (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_req     (sw_req),
        .sw_sel     (sw_sel),
        .gate_dly   (gate_dly),
        .settle_dly (settle_dly),
        .sw_ack     (sw_ack),
        .mux_s      (mux_s),
        .gate_en    (gate_en),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Vector order: {busy, gate_en, mux_s, sw_ack}, value after edge cyc.
    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] act;
        act = {busy, gate_en, mux_s, sw_ack};
        while (sb_q.size() > 0 && sb_q[0].cyc <= edge_n) begin
            e = sb_q.pop_front();
            n_tests++;
            if (e.cyc != edge_n) begin
                n_fail++;
                $display("FAIL %s: check for edge %0d missed, now at edge %0d", e.name, e.cyc, edge_n);
            end else if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s @edge %0d: {busy,gate_en,mux_s,sw_ack} got %b want %b",
                         e.name, edge_n, act, e.exp);
            end
        end
    end

    task automatic push(input int c, input logic [3:0] v, input string nm);
        sb_q.push_back('{c, v, nm});
    endtask

    task automatic push_rng(input int c0, input int c1, input logic [3:0] v, input string nm);
        for (int c = c0; c <= c1; c++) push(c, v, nm);
    endtask

    // Returns 1ns after edge n; inputs driven here are sampled at edge n+1.
    task automatic go_to_edge(input int n);
        while (edge_n < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst        = 1'b1;
        sw_req     = 1'b0;
        sw_sel     = 1'b0;
        gate_dly   = '0;
        settle_dly = '0;

        // Reset, then INIT_CYC=8 count-down
        push_rng(1, 3, 4'b1000, "reset_vals");
        go_to_edge(3);
        rst = 1'b0;
        push_rng(4, 11, 4'b1000, "init_wait");
        push(12, 4'b0100, "init_done");

        // 0 -> 1, G=2 S=3, accept at 15
        go_to_edge(14);
        push(15, 4'b0100, "s2_accept");
        push_rng(16, 17, 4'b1000, "s2_gate");
        push_rng(18, 20, 4'b1010, "s2_switch");
        push_rng(21, 22, 4'b1110, "s2_ungate");
        push_rng(23, 25, 4'b1111, "s2_ack");
        push(26, 4'b0110, "s2_release");
        sw_req = 1'b1; sw_sel = 1'b1; gate_dly = 4'd2; settle_dly = 4'd3;
        go_to_edge(24);
        sw_req = 1'b0;

        // 1 -> 0, zero dwells clamp to 1, accept at 30
        go_to_edge(29);
        push(30, 4'b0110, "s3_accept");
        push(31, 4'b1010, "s3_gate");
        push(32, 4'b1000, "s3_switch");
        push(33, 4'b1100, "s3_ungate");
        push_rng(34, 35, 4'b1101, "s3_ack");
        push(36, 4'b0100, "s3_release");
        sw_req = 1'b1; sw_sel = 1'b0; gate_dly = 4'd0; settle_dly = 4'd0;
        go_to_edge(34);
        sw_req = 1'b0;

        // Same-source request, accept at 40
        go_to_edge(39);
        push(40, 4'b0100, "s4_accept");
        push_rng(41, 43, 4'b1101, "s4_ack");
        push(44, 4'b0100, "s4_release");
        sw_req = 1'b1; sw_sel = 1'b0; gate_dly = 4'd3; settle_dly = 4'd3;
        go_to_edge(42);
        sw_req = 1'b0;

        // 0 -> 1, G=1 S=2, req dropped and config changed in SWITCH
        go_to_edge(49);
        push(50, 4'b0100, "s5_accept");
        push(51, 4'b1000, "s5_gate");
        push_rng(52, 53, 4'b1010, "s5_switch");
        push_rng(54, 55, 4'b1110, "s5_ungate_noack");
        push(56, 4'b0110, "s5_idle");
        sw_req = 1'b1; sw_sel = 1'b1; gate_dly = 4'd1; settle_dly = 4'd2;
        go_to_edge(51);
        sw_req = 1'b0; sw_sel = 1'b0; gate_dly = 4'd7; settle_dly = 4'd9;

        // 1 -> 0 request, reset on SWITCH entry while mux_s=1, req held through INIT
        go_to_edge(59);
        push(60, 4'b0110, "s6_accept");
        push_rng(61, 63, 4'b1000, "s6_rst_mid");
        push_rng(64, 71, 4'b1000, "s6_reinit");
        push(72, 4'b0100, "s6_first_idle");
        push_rng(73, 75, 4'b1101, "s6_held_req_ack");
        push(76, 4'b0100, "s6_release");
        sw_req = 1'b1; sw_sel = 1'b0; gate_dly = 4'd1; settle_dly = 4'd4;
        go_to_edge(61);
        rst = 1'b1;
        go_to_edge(63);
        rst = 1'b0;
        go_to_edge(74);
        sw_req = 1'b0;

        go_to_edge(78);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aibnd_dcc_mux_ctrl.md
# aibnd_dcc_mux_ctrl

Sequencing controller for the DCC clock-source mux select. The block accepts a source-change request over a 4-phase req/ack handshake and steps through a fixed sequence: gate downstream, flip the mux select, wait for settle, un-gate, then acknowledge. This guarantees no runt clock pulses reach the DCC chain. It sits beside the 2:1 DCC clock mux and drives its select and the downstream clock-gate enable from a single free-running control clock.

## Interface
- CNT_W, 4, width of delay/settle counters and config inputs
- INIT_CYC, 8, cycles after reset release before gate enable first asserts (1..2^CNT_W-1)
- RST_SEL, 1'b0, mux select value held during and after reset
- clk  in  1  control clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- sw_req  in  1  source-change request (level, 4-phase)
- sw_sel  in  1  requested mux source (0 = clk0, 1 = clk1); sampled on acceptance
- gate_dly  in  CNT_W  cycles spent in GATE and in UNGATE; sampled on acceptance
- settle_dly  in  CNT_W  cycles spent in SWITCH; sampled on acceptance
- sw_ack  out  1  handshake acknowledge
- mux_s  out  1  registered select to clock mux
- gate_en  out  1  registered enable to downstream clock gate
- busy  out  1  high in every state except IDLE

## Operation
- States: INIT, IDLE, GATE, SWITCH, UNGATE, DONE. All outputs are registered and Moore-decoded.
- Reset (asynchronous): state=INIT, mux_s=RST_SEL, gate_en=0, sw_ack=0, busy=1, counter loaded with INIT_CYC.
- INIT: count down INIT_CYC cycles. Then go to IDLE and set gate_en=1. A sw_req raised during INIT is held off and accepted on the first IDLE cycle.
- IDLE: on sw_req=1, latch sw_sel, gate_dly and settle_dly.
  - If sw_sel == mux_s, go directly to DONE. No gating, no select change.
  - Otherwise go to GATE.
- GATE: gate_en=0 on entry. Dwell for max(gate_dly,1) cycles, then go to SWITCH.
- SWITCH: mux_s = latched sw_sel on entry. Dwell for max(settle_dly,1) cycles, then go to UNGATE.
- UNGATE: gate_en=1 on entry. Dwell for max(gate_dly,1) cycles, then go to DONE.
- DONE: sw_ack=1 while sw_req=1. When sw_req=0, sw_ack=0 and go to IDLE.
- Dwell value 0 is treated as 1. The counter never wraps: it is loaded at phase entry and decremented to terminal.
- sw_sel, gate_dly and settle_dly changes after acceptance are ignored until the next IDLE acceptance.
- sw_req dropped mid-sequence: the sequence still completes. On reaching DONE with sw_req=0, sw_ack stays 0 and the next state is IDLE.
- A new request is only accepted in IDLE. Back-to-back requests need sw_req low for at least one cycle in DONE.
- Reset mid-sequence: all outputs return to their reset values immediately, and INIT runs again. mux_s reverts to RST_SEL.

## Timing
- Accept at edge k (IDLE, sw_req=1, sw_sel≠mux_s), with G=max(gate_dly,1) and S=max(settle_dly,1):
  - gate_en=0 from k+1
  - mux_s changes at k+1+G
  - gate_en=1 at k+1+G+S
  - sw_ack=1 at k+1+2G+S
- Same-source request accepted at k: sw_ack=1 at k+1.
- sw_ack falls one cycle after sw_req falls. busy falls in the same cycle.
- After reset release, gate_en rises INIT_CYC cycles after the first clk edge.
- gate_en and mux_s never change in the same cycle.

## Structure
- Shared package aibnd_dcc_pkg holds:
  - state enum (INIT, IDLE, GATE, SWITCH, UNGATE, DONE)
  - CNT_W default
  - helper for the max(x,1) dwell clamp
- One sub-module, aibnd_dcc_dly_cnt: loadable down-counter with terminal flag. It handles the zero-to-one clamp on load and holds at terminal.

## Test plan
- Reset with RST_SEL=0, INIT_CYC=8 -> mux_s=0, gate_en=0, busy=1 during reset. gate_en=1 and busy=0 exactly 8 cycles after release.
- gate_dly=2, settle_dly=3, sw_sel=1, req at edge 10 -> gate_en low at 11, mux_s=1 at 13, gate_en high at 16, sw_ack at 18. Drop req at 20 -> sw_ack=0 and busy=0 at 21.
- gate_dly=0, settle_dly=0 -> each phase dwells 1 cycle. sw_ack 4 cycles after acceptance.
- sw_sel equal to current mux_s -> sw_ack next cycle. gate_en stays 1 and mux_s stays unchanged throughout.
- sw_req dropped in SWITCH, and sw_sel/gate_dly changed mid-sequence -> sequence completes with the latched values, sw_ack never asserts, return to IDLE.
- rst asserted during SWITCH with mux_s=1, RST_SEL=0 -> immediate mux_s=0, gate_en=0, sw_ack=0. INIT re-runs, and a held sw_req is accepted on the first IDLE cycle.
